// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - SRAM pin-group strobes and address, controller (master) to responder (slave)
interface sram_responder_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport master (output sram_addr, output sram_ce_n, output sram_oe_n, output sram_we_n);
  modport slave  (input  sram_addr, input  sram_ce_n, input  sram_oe_n, input  sram_we_n);
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - clocked emulation of an async 32-bit SRAM chip with programmable read latency
// Optional protocol checker enabled by defining SRAM_RESP_PROTCHK_EN.
module sram_responder #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_responder_if.slave    bus,
  inout  wire  [DATA_W-1:0]  sram_data,
  output logic               busy,
  output logic [15:0]        wr_count,
  output logic               proto_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_WAIT  = 2'd2,
    RD_DRIVE = 2'd3
  } state_t;

  localparam logic [2:0] CNT_INIT = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);

  state_t                  state, state_d;
  logic [2:0]              cnt, cnt_d;
  logic [DEPTH_LOG2-1:0]   wa, wa_d;
  logic [DATA_W-1:0]       wd, wd_d;
  logic                    drive_en, drive_d;
  logic                    commit;
  logic                    rd_abort;
  logic [DATA_W-1:0]       rdata;

  logic                    ce_q, oe_q, we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       data_q;
  logic [DEPTH_LOG2-1:0]   idx;

  logic [DATA_W-1:0]       mem [2**DEPTH_LOG2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q   <= 1'b1;
      oe_q   <= 1'b1;
      we_q   <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ce_q   <= bus.sram_ce_n;
      oe_q   <= bus.sram_oe_n;
      we_q   <= bus.sram_we_n;
      addr_q <= bus.sram_addr;
      data_q <= sram_data;
    end
  end

  // Upper address bits alias onto the same storage word.
  assign idx      = addr_q[DEPTH_LOG2-1:0];
  assign rd_abort = ce_q | oe_q | ~we_q;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wa_d    = wa;
    wd_d    = wd;
    drive_d = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (!ce_q && !we_q) begin
          state_d = WRITE;
          wa_d    = idx;
          wd_d    = data_q;
        end else if (!ce_q && !oe_q) begin
          if (RD_LAT == 0) begin
            state_d = RD_DRIVE;
            drive_d = 1'b1;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WRITE: begin
        if (!ce_q && !we_q) begin
          wa_d = idx;
          wd_d = data_q;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (rd_abort) begin
          state_d = IDLE;
        end else if (cnt == 3'd0) begin
          state_d = RD_DRIVE;
          drive_d = 1'b1;
        end else begin
          cnt_d = cnt - 3'd1;
        end
      end
      RD_DRIVE: begin
        if (rd_abort) begin
          state_d = IDLE;
        end else begin
          drive_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wa       <= '0;
      wd       <= '0;
      drive_en <= 1'b0;
      busy     <= 1'b0;
      wr_count <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      wa       <= wa_d;
      wd       <= wd_d;
      drive_en <= drive_d;
      busy     <= (state_d != IDLE);
      if (commit) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  // Storage is deliberately not reset; a read sharing an edge with a commit sees the old word.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[wa] <= wd;
    end
    if (drive_d) begin
      rdata <= mem[idx];
    end
  end

  assign sram_data = drive_en ? rdata : {DATA_W{1'bz}};

`ifdef SRAM_RESP_PROTCHK_EN
  logic [ADDR_W-1:0] addr_lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_lat  <= '0;
      proto_err <= 1'b0;
    end else begin
      if ((state == IDLE || state == WRITE) && !ce_q && !we_q) begin
        addr_lat <= addr_q;
      end
      if ((!ce_q && !oe_q && !we_q) ||
          (state == WRITE && !we_q && addr_q != addr_lat)) begin
        proto_err <= 1'b1;
      end
    end
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, addr_q[ADDR_W-1:DEPTH_LOG2]};
  assign proto_err      = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - table-driven write/read vectors plus hand sequences for abort, re-latch and reset cases
module tb_sram_responder;
  localparam int RD_LAT = 3;
`ifdef SRAM_RESP_PROTCHK_EN
  localparam logic PROTCHK = 1'b1;
`else
  localparam logic PROTCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy;
  logic [15:0] wr_count;
  logic        proto_err;
  logic        tb_den = 1'b0;
  logic [31:0] tb_wdata = '0;
  wire  [31:0] sram_data;

  sram_responder_if #(.ADDR_W(20)) bus ();

  assign sram_data = tb_den ? tb_wdata : 32'bz;

  sram_responder #(.ADDR_W(20), .DATA_W(32), .DEPTH_LOG2(10), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sram_data(sram_data),
    .busy(busy), .wr_count(wr_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [19:0] addr;
    logic [31:0] data;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes_idle();
    bus.sram_ce_n = 1'b1;
    bus.sram_oe_n = 1'b1;
    bus.sram_we_n = 1'b1;
    tb_den        = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [31:0] d, input logic oe_low,
                          input logic [15:0] exp_wc);
    bus.sram_addr = a;
    tb_wdata      = d;
    tb_den        = 1'b1;
    bus.sram_ce_n = 1'b0;
    bus.sram_we_n = 1'b0;
    bus.sram_oe_n = ~oe_low;
    tick();
    strobes_idle();
    tick();
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_no_drive", 32'(dut.drive_en), 32'd0);
    tick();
    check("wr_count", 32'(wr_count), 32'(exp_wc));
    check("wr_idle", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic start_read(input logic [19:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus.sram_addr = a;
    bus.sram_ce_n = 1'b0;
    bus.sram_oe_n = 1'b0;
  endtask

  task automatic wait_drive();
    int n = 0;
    logic [31:0] e;
    while (!dut.drive_en && n < 20) begin
      tick();
      n++;
    end
    check("rd_latency", 32'(n), 32'(RD_LAT + 2));
    e = exp_q.pop_front();
    check("rd_data", sram_data, e);
  endtask

  task automatic end_read();
    strobes_idle();
    tick();
    check("rd_hold_one", 32'(dut.drive_en), 32'd1);
    tick();
    check("rd_release", 32'(dut.drive_en), 32'd0);
    check("rd_idle", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic do_read(input logic [19:0] a, input logic [31:0] exp);
    start_read(a, exp);
    wait_drive();
    end_read();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 20'h00010, 32'hDEADBEEF, 16'd1};
    tbl[1]  = '{1'b0, 20'h00010, 32'hDEADBEEF, 16'd1};
    tbl[2]  = '{1'b1, 20'h00405, 32'h00001234, 16'd2};
    tbl[3]  = '{1'b0, 20'h00005, 32'h00001234, 16'd2};
    tbl[4]  = '{1'b1, 20'h003FF, 32'hA5A5A5A5, 16'd3};
    tbl[5]  = '{1'b0, 20'h003FF, 32'hA5A5A5A5, 16'd3};
    tbl[6]  = '{1'b1, 20'hFFC00, 32'h00000001, 16'd4};
    tbl[7]  = '{1'b0, 20'h00000, 32'h00000001, 16'd4};
    tbl[8]  = '{1'b1, 20'h00010, 32'hCAFEF00D, 16'd5};
    tbl[9]  = '{1'b0, 20'h00410, 32'hCAFEF00D, 16'd5};
    tbl[10] = '{1'b1, 20'h00020, 32'h11111111, 16'd6};
    tbl[11] = '{1'b0, 20'h00005, 32'h00001234, 16'd6};

    bus.sram_addr = '0;
    strobes_idle();
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_drive", 32'(dut.drive_en), 32'd0);
    check("rst_proto", 32'(proto_err), 32'd0);
    rst = 1'b1;
    repeat (2) tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_wr_count", 32'(wr_count), 32'd0);
    check("post_rst_drive", 32'(dut.drive_en), 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data, 1'b0, tbl[i].exp_wc);
      else begin
        do_read(tbl[i].addr, tbl[i].data);
        check("rd_wr_count", 32'(wr_count), 32'(tbl[i].exp_wc));
      end
    end
    check("no_proto_clean", 32'(proto_err), 32'd0);

    // Address change while driving is followed one cycle after it is sampled.
    start_read(20'h00010, 32'hCAFEF00D);
    wait_drive();
    bus.sram_addr = 20'h003FF;
    tick();
    tick();
    check("rd_follow", sram_data, 32'hA5A5A5A5);
    end_read();

    // Abort during RD_WAIT: bus must never be driven.
    bus.sram_addr = 20'h00010;
    bus.sram_ce_n = 1'b0;
    bus.sram_oe_n = 1'b0;
    tick();
    tick();
    bus.sram_oe_n = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (dut.drive_en) seen = 1'b1;
      end
      check("abort_no_drive", 32'(seen), 32'd0);
    end
    check("abort_idle", 32'(busy), 32'd0);
    strobes_idle();
    tick();

    // Held write strobe: address/data re-latched, last one commits.
    do_write(20'h00040, 32'h40404040, 1'b0, 16'd7);
    tb_den = 1'b1;
    bus.sram_ce_n = 1'b0;
    bus.sram_we_n = 1'b0;
    bus.sram_addr = 20'h00040; tb_wdata = 32'h0BAD0001; tick();
    bus.sram_addr = 20'h00041; tb_wdata = 32'h0BAD0002; tick();
    bus.sram_addr = 20'h00042; tb_wdata = 32'h600D0003; tick();
    strobes_idle();
    tick();
    tick();
    check("relatch_wr_count", 32'(wr_count), 32'd8);
    check("relatch_proto", 32'(proto_err), 32'(PROTCHK));
    tick();
    do_read(20'h00042, 32'h600D0003);
    do_read(20'h00040, 32'h40404040);

    // Reset in the middle of a write discards it.
    bus.sram_addr = 20'h00020;
    tb_wdata      = 32'h99999999;
    tb_den        = 1'b1;
    bus.sram_ce_n = 1'b0;
    bus.sram_we_n = 1'b0;
    tick();
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #2;
    check("async_rst_busy", 32'(busy), 32'd0);
    strobes_idle();
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("rst_wr_discard_count", 32'(wr_count), 32'd0);
    check("rst_proto_clear", 32'(proto_err), 32'd0);
    do_read(20'h00020, 32'h11111111);

    // All strobes low: write wins; checker flags it when enabled.
    do_write(20'h00030, 32'h55AA55AA, 1'b1, 16'd1);
    check("all_low_proto", 32'(proto_err), 32'(PROTCHK));
    do_read(20'h00030, 32'h55AA55AA);
    check("proto_sticky", 32'(proto_err), 32'(PROTCHK));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
